// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared definitions for the 5-stage RISC-V pipeline control.
//   FWD_RF / FWD_WB / FWD_MEM : operand mux select encodings used by the EX
//                               muxes and by the forwarding controller.
//   stage_t                   : destination/source metadata carried by each
//                               shadow pipeline stage.
//   stage_match()             : true when a stage will write a register that
//                               a used source reads (x0 never matches).
package rv_pipe_pkg;

  localparam int RV_REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic                valid;
    logic [RV_REG_W-1:0] rs1;
    logic [RV_REG_W-1:0] rs2;
    logic                rs1_used;
    logic                rs2_used;
    logic [RV_REG_W-1:0] rd;
    logic                regwrite;
    logic                memread;
  } stage_t;

  function automatic logic stage_match(input stage_t              s,
                                       input logic [RV_REG_W-1:0] r,
                                       input logic                used);
    return s.valid && s.regwrite && (s.rd != '0) && (s.rd == r) && used;
  endfunction

endpackage

// File: rtl/fwd_sel_cmp.sv
// fwd_sel_cmp: per-operand forwarding priority comparator.
//   ex_valid_i : EX shadow entry holds a real instruction
//   src_i      : source register index read by the EX instruction
//   src_used_i : that source is actually read
//   mem_i      : MEM shadow entry
//   wb_i       : WB shadow entry
//   sel_o      : operand mux select (FWD_MEM beats FWD_WB beats FWD_RF)
module fwd_sel_cmp
  import rv_pipe_pkg::*;
(
  input  logic                ex_valid_i,
  input  logic [RV_REG_W-1:0] src_i,
  input  logic                src_used_i,
  input  stage_t              mem_i,
  input  stage_t              wb_i,
  output logic [1:0]          sel_o
);

  // MEM holds the youngest producer, so it is checked first.
  always_comb begin
    sel_o = FWD_RF;
    if (ex_valid_i) begin
      if (stage_match(mem_i, src_i, src_used_i)) begin
        sel_o = FWD_MEM;
      end else if (stage_match(wb_i, src_i, src_used_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/rv_fwd_ctrl.sv
// rv_fwd_ctrl: forwarding and load-use hazard controller for the 5-stage
// RISC-V pipeline.
//   clk_i, rst_i            : clock, asynchronous active-low reset
//   id_*                    : metadata of the instruction currently in ID
//   flush_i                 : branch/jump taken in EX, squash the ID instruction
//   stall_o                 : hold PC and IF/ID, inject a bubble into EX
//   fwd_a_o, fwd_b_o        : EX operand mux selects (registered state only)
//   stall_cnt_o             : saturating count of stall cycles
// REG_W must equal rv_pipe_pkg::RV_REG_W, which sizes the shadow entries.
module rv_fwd_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int REG_W = RV_REG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [REG_W-1:0] id_rd_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  stage_t           id_entry;
  stage_t           ex_d, ex_q;
  stage_t           mem_d, mem_q;
  stage_t           wb_d, wb_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic             ex_load_hit;

  always_comb begin
    id_entry          = '0;
    id_entry.valid    = id_valid_i;
    id_entry.rs1      = id_rs1_i;
    id_entry.rs2      = id_rs2_i;
    id_entry.rs1_used = id_rs1_used_i;
    id_entry.rs2_used = id_rs2_used_i;
    id_entry.rd       = id_rd_i;
    id_entry.regwrite = id_regwrite_i;
    id_entry.memread  = id_memread_i;
  end

  // Load in EX feeding the ID instruction: its data is only available from
  // WB, so one bubble lines the consumer up with the WB forward path.
  always_comb begin
    ex_load_hit = ex_q.memread &&
                  (stage_match(ex_q, id_rs1_i, id_rs1_used_i) ||
                   stage_match(ex_q, id_rs2_i, id_rs2_used_i));
    stall_o     = ex_load_hit && id_valid_i && !flush_i;
  end

  always_comb begin
    ex_d  = id_entry;
    mem_d = ex_q;
    wb_d  = mem_q;
    if (flush_i || stall_o) begin
      ex_d.valid = 1'b0;
    end
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // ---- ID -> EX -> MEM -> WB shadow stages ----
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

  fwd_sel_cmp u_fwd_a (
    .ex_valid_i (ex_q.valid),
    .src_i      (ex_q.rs1),
    .src_used_i (ex_q.rs1_used),
    .mem_i      (mem_q),
    .wb_i       (wb_q),
    .sel_o      (fwd_a_o)
  );

  fwd_sel_cmp u_fwd_b (
    .ex_valid_i (ex_q.valid),
    .src_i      (ex_q.rs2),
    .src_used_i (ex_q.rs2_used),
    .mem_i      (mem_q),
    .wb_i       (wb_q),
    .sel_o      (fwd_b_o)
  );

  // A load in MEM never has its data forwarded; the load-use bubble must
  // keep any dependent instruction out of EX until the load reaches WB.
  a_no_mem_load_fwd : assert property (@(posedge clk_i) disable iff (!rst_i)
    !(ex_q.valid && mem_q.memread &&
      (stage_match(mem_q, ex_q.rs1, ex_q.rs1_used) ||
       stage_match(mem_q, ex_q.rs2, ex_q.rs2_used))));

endmodule

// File: doc/rv_fwd_ctrl.md
# rv_fwd_ctrl

Forwarding and load-use hazard controller for the 5-stage RISC-V pipeline. It drives the 2-bit select inputs of the two EX-stage operand 3-to-1 muxes (`00` = register file, `01` = MEM/WB result, `10` = EX/MEM result). It tracks destination-register metadata through its own EX/MEM/WB shadow registers. It also raises a one-cycle stall for load-use hazards and counts stall cycles for performance monitoring.

## Interface

Parameters:
- `REG_W`, default 5: register index width.
- `CNT_W`, default 16: stall counter width.

Ports:
- `clk_i`  in  1  pipeline clock.
- `rst_i`  in  1  asynchronous, active-low reset.
- `id_valid_i`  in  1  ID stage holds a real instruction.
- `id_rs1_i`, `id_rs2_i`  in  REG_W  source indices of the ID instruction.
- `id_rs1_used_i`, `id_rs2_used_i`  in  1  source actually read (U/J-type: 0).
- `id_rd_i`  in  REG_W  destination index.
- `id_regwrite_i`  in  1  instruction writes rd.
- `id_memread_i`  in  1  instruction is a load.
- `flush_i`  in  1  taken branch/jump resolved in EX; squash the ID instruction.
- `stall_o`  out  1  hold PC and IF/ID, bubble into EX.
- `fwd_a_o`, `fwd_b_o`  out  2  operand A/B mux selects for the EX stage.
- `stall_cnt_o`  out  CNT_W  saturating count of stall cycles.

## Operation

**Shadow stages.** Each stage holds the fields {valid, rs1, rs2, rs1_used, rs2_used, rd, regwrite, memread}. Only EX needs the rs fields.

**Advance every cycle:**
- WB ← MEM.
- MEM ← EX.
- EX ← ID entry, or a bubble (valid=0) when `flush_i` or `stall_o` is 1.

**Hazard match.** Stage S matches source r when all of the following hold:
- S.valid
- S.regwrite
- S.rd ≠ 0
- S.rd == r
- the source is used

**Forward select (per operand, EX entry):**
- `10` if MEM matches.
- Else `01` if WB matches.
- Else `00`.
- MEM wins over WB (youngest producer).
- x0 never forwards.
- When the EX entry is invalid: `00`.

**Load-use.** `stall_o` = EX.valid & EX.memread & EX.regwrite & EX.rd ≠ 0 & (EX.rd matches a used ID source) & `id_valid_i` & !`flush_i`.
- One bubble is always sufficient.
- The next cycle the load sits in MEM, and MEM-stage load data is never forwarded: its select resolves to `01` from WB one cycle later.
- Consequently a MEM-stage match with MEM.memread=1 must never occur. This is an assertion.

**Flush.** Flush takes priority over stall: `stall_o` = 0 and EX receives a bubble.

**Register file.** The register file writes in the first half-cycle, so WB→ID needs no forwarding here.

**Stall counter.** Increments when `stall_o` = 1 and saturates at all-ones.

## Timing

- Reset values:
  - All shadow valid bits = 0.
  - `fwd_a_o` = `fwd_b_o` = `00`.
  - `stall_o` = 0.
  - `stall_cnt_o` = 0.
- `fwd_a_o` and `fwd_b_o` are combinational from registered shadow state only, with no input-to-output path. They are valid early in the cycle.
- `stall_o` is combinational from the ID inputs and the EX shadow, the same cycle the ID instruction is presented. The ID inputs stay stable during the stall because IF/ID is held upstream.
- Latency: a producer in EX at cycle t gives select `10` to a consumer in EX at t+1, and `01` to one in EX at t+2.
- A reset asserted mid-operation clears all shadows immediately (asynchronously). The first cycle after release behaves as an empty pipeline.
- Simultaneous `flush_i` and a load-use condition: no stall, bubble into EX, and the counter does not increment.

## Structure

- Shared package `rv_pipe_pkg` holds:
  - Constants `FWD_RF` = 2'b00, `FWD_WB` = 2'b01, `FWD_MEM` = 2'b10. The muxes and this block both use these.
  - The shadow-stage entry struct.
- Sub-module `fwd_sel_cmp` is instantiated twice, once per operand. It is the per-operand priority comparator, taking the EX source, the MEM entry and the WB entry, and producing the 2-bit select.
- Top level holds the shadow registers, the stall logic and the counter.

## Test plan

- **Back-to-back ALU dependency.** `add x5,x1,x2` then `sub x6,x5,x3`. When sub is in EX: `fwd_a_o` = `10`, `fwd_b_o` = `00`, no stall.
- **Distance-2 dependency with double producer.**
  - `add x5`, `nop`, `or x7,x4,x5`: `fwd_b_o` = `01`.
  - Same sequence with a second `add x5` in between: `fwd_b_o` = `10` (MEM priority).
- **Load-use.** `lw x8,0(x1)` then `add x9,x8,x8`.
  - `stall_o` = 1 for exactly one cycle.
  - EX gets a bubble (selects `00`).
  - Next cycle add in EX has both selects `01`.
  - `stall_cnt_o` increments by 1.
- **x0 and unused sources.**
  - `addi x0,...` followed by a consumer of x0: selects `00`.
  - `lw x5` followed by `lui x5`, whose rs1 field equals 5 but is unused: `stall_o` = 0.
- **Flush and reset.**
  - `flush_i` asserted together with a load-use condition: `stall_o` = 0, EX bubble, counter unchanged.
  - `rst_i` pulsed low mid-stream: all outputs 0 immediately.
  - Counter forced to all-ones plus another stall: stays all-ones.
